metric_memory_pp: RTL and testbench

//  Parametrised ping-pong path-metric store for the Viterbi ACS loop; successor to METRICMEMORY.
//  Two banks: ACS writes new metrics to one bank while it reads old metrics from the other; the banks swap per trellis step.

---
 rtl/metric_memory_pp_pkg.sv | 14 +
 rtl/metric_memory_pp_bank_ram.sv | 25 ++
 rtl/metric_memory_pp.sv | 172 +++++++++++++++++
 tb/tb_metric_memory_pp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/metric_memory_pp_pkg.sv
// Shared defaults and the step-control state type for the ping-pong path-metric store.
package metric_memory_pp_pkg;

    localparam int          MM_WD_METR   = 8;
    localparam int          MM_N_ACS     = 4;
    localparam int          MM_N_STATE   = 256;
    localparam logic [7:0]  MM_INIT_METR = 8'h3F;

    typedef enum logic {
        MM_INIT = 1'b0,
        MM_RUN  = 1'b1
    } mm_state_e;

endpackage

// File: rtl/metric_memory_pp_bank_ram.sv
// One half-bank of metric storage: synchronous write, combinational read; the top registers the read path.
module mm_bank_ram #(
    parameter int DW    = 32,
    parameter int WORDS = 32,
    localparam int RAW  = $clog2(WORDS)
) (
    input  logic           Clock1,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] raddr,
    output logic [DW-1:0]  rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge Clock1) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/metric_memory_pp.sv
// Ping-pong path-metric store for the Viterbi ACS loop: two banks swap every trellis step,
// with init-step metrics, MSB renormalisation and a per-step write-count check.
//
//   state   | meaning
//   MM_INIT | first step after reset; reads return start-state metrics, no step error
//   MM_RUN  | normal operation; reads come from the read bank
module metric_memory_pp
    import metric_memory_pp_pkg::*;
#(
    parameter int                 WD_METR   = MM_WD_METR,
    parameter int                 N_ACS     = MM_N_ACS,
    parameter int                 N_STATE   = MM_N_STATE,
    parameter logic [WD_METR-1:0] INIT_METR = WD_METR'(MM_INIT_METR),
    localparam int                DEPTH     = N_STATE / N_ACS,
    localparam int                AW        = $clog2(DEPTH)
) (
    input  logic                       Clock1,
    input  logic                       Reset,
    input  logic                       Active,
    input  logic                       MMWriteEnable,
    input  logic [AW-1:0]              MMWriteAddress,
    input  logic [N_ACS*WD_METR-1:0]   MMMetric,
    input  logic                       MMReadEnable,
    input  logic [AW-2:0]              MMReadAddress,
    input  logic                       MMSwap,
    output logic [2*N_ACS*WD_METR-1:0] MMPathMetric,
    output logic                       MMReadValid,
    output logic                       MMBlockSelect,
    output logic                       MMNormApplied,
    output logic                       MMStepError
);

    localparam int WW = N_ACS * WD_METR;
    localparam int CW = $clog2(DEPTH + 2);

    mm_state_e     state, state_next;
    logic          init_mode;
    logic [CW-1:0] step_cnt, cnt_eff;
    logic          tracker, trk_eff, wr_msb_and;
    logic          wr_fire, rd_fire, sw_fire;

    logic [WW-1:0]   rd_a_even, rd_a_odd, rd_b_even, rd_b_odd;
    logic [2*WW-1:0] raw_word, init_word, msb_mask, rd_word;

    assign wr_fire = Active & MMWriteEnable;
    assign rd_fire = Active & MMReadEnable;
    assign sw_fire = Active & MMSwap;

    // Write bank is A when select=0; the LSB of the word address picks the even/odd half.
    mm_bank_ram #(.DW(WW), .WORDS(DEPTH/2)) u_ram_a_even (
        .Clock1 (Clock1),
        .we     (wr_fire & ~MMBlockSelect & ~MMWriteAddress[0]),
        .waddr  (MMWriteAddress[AW-1:1]),
        .wdata  (MMMetric),
        .raddr  (MMReadAddress),
        .rdata  (rd_a_even)
    );

    mm_bank_ram #(.DW(WW), .WORDS(DEPTH/2)) u_ram_a_odd (
        .Clock1 (Clock1),
        .we     (wr_fire & ~MMBlockSelect & MMWriteAddress[0]),
        .waddr  (MMWriteAddress[AW-1:1]),
        .wdata  (MMMetric),
        .raddr  (MMReadAddress),
        .rdata  (rd_a_odd)
    );

    mm_bank_ram #(.DW(WW), .WORDS(DEPTH/2)) u_ram_b_even (
        .Clock1 (Clock1),
        .we     (wr_fire & MMBlockSelect & ~MMWriteAddress[0]),
        .waddr  (MMWriteAddress[AW-1:1]),
        .wdata  (MMMetric),
        .raddr  (MMReadAddress),
        .rdata  (rd_b_even)
    );

    mm_bank_ram #(.DW(WW), .WORDS(DEPTH/2)) u_ram_b_odd (
        .Clock1 (Clock1),
        .we     (wr_fire & MMBlockSelect & MMWriteAddress[0]),
        .waddr  (MMWriteAddress[AW-1:1]),
        .wdata  (MMMetric),
        .raddr  (MMReadAddress),
        .rdata  (rd_b_odd)
    );

    assign raw_word = MMBlockSelect ? {rd_a_odd, rd_a_even} : {rd_b_odd, rd_b_even};

    always_comb begin
        init_word = '0;
        msb_mask  = '0;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < N_ACS; k++) begin
                msb_mask[(j*N_ACS + k)*WD_METR + WD_METR - 1] = 1'b1;
                if (!(MMReadAddress == '0 && j == 0 && k == 0)) begin
                    init_word[(j*N_ACS + k)*WD_METR +: WD_METR] = INIT_METR;
                end
            end
        end
    end

    always_comb begin
        rd_word = raw_word;
        if (init_mode) begin
            rd_word = init_word;
        end else if (MMNormApplied) begin
            rd_word = raw_word & ~msb_mask;
        end
    end

    // A write in the swap cycle still belongs to the closing step.
    always_comb begin
        wr_msb_and = 1'b1;
        for (int k = 0; k < N_ACS; k++) begin
            wr_msb_and = wr_msb_and & MMMetric[k*WD_METR + WD_METR - 1];
        end
    end

    always_comb begin
        cnt_eff = step_cnt;
        if (wr_fire && step_cnt != CW'(DEPTH + 1)) begin
            cnt_eff = step_cnt + CW'(1);
        end
    end

    assign trk_eff = tracker & (~wr_fire | wr_msb_and);

    always_comb begin
        state_next = state;
        if (sw_fire) begin
            state_next = MM_RUN;
        end
    end

    always_ff @(posedge Clock1) begin
        if (!Reset) begin
            state <= MM_INIT;
        end else begin
            state <= state_next;
        end
    end

    assign init_mode = (state == MM_INIT);

    always_ff @(posedge Clock1) begin
        if (!Reset) begin
            MMPathMetric  <= '0;
            MMReadValid   <= 1'b0;
            MMBlockSelect <= 1'b0;
            MMNormApplied <= 1'b0;
            MMStepError   <= 1'b0;
            step_cnt      <= '0;
            tracker       <= 1'b1;
        end else begin
            MMReadValid <= rd_fire;
            MMStepError <= 1'b0;
            if (rd_fire) begin
                MMPathMetric <= rd_word;
            end
            if (sw_fire) begin
                MMBlockSelect <= ~MMBlockSelect;
                MMNormApplied <= trk_eff & ~init_mode;
                MMStepError   <= (cnt_eff != CW'(DEPTH)) & ~init_mode;
                step_cnt      <= '0;
                tracker       <= 1'b1;
            end else begin
                step_cnt <= cnt_eff;
                tracker  <= trk_eff;
            end
        end
    end

endmodule

// File: tb/tb_metric_memory_pp.sv
// Self-checking bench for metric_memory_pp against a step-level behavioural model of the metric store.
module tb_metric_memory_pp;

    logic        Clock1 = 1'b0;
    logic        Reset = 1'b0, Active = 1'b0, MMWriteEnable = 1'b0, MMReadEnable = 1'b0, MMSwap = 1'b0;
    logic [5:0]  MMWriteAddress = '0;
    logic [31:0] MMMetric = '0;
    logic [4:0]  MMReadAddress = '0;
    logic [63:0] MMPathMetric;
    logic        MMReadValid, MMBlockSelect, MMNormApplied, MMStepError;

    always #5 Clock1 = ~Clock1;

    metric_memory_pp dut (
        .Clock1         (Clock1),
        .Reset          (Reset),
        .Active         (Active),
        .MMWriteEnable  (MMWriteEnable),
        .MMWriteAddress (MMWriteAddress),
        .MMMetric       (MMMetric),
        .MMReadEnable   (MMReadEnable),
        .MMReadAddress  (MMReadAddress),
        .MMSwap         (MMSwap),
        .MMPathMetric   (MMPathMetric),
        .MMReadValid    (MMReadValid),
        .MMBlockSelect  (MMBlockSelect),
        .MMNormApplied  (MMNormApplied),
        .MMStepError    (MMStepError)
    );

    int checks = 0;
    int failures = 0;

    // Model: bank 0 = A, bank 1 = B; the write bank index equals the select bit.
    logic [31:0] bank [2][64];
    bit          m_sel, m_init, m_norm, m_trk;
    int          m_cnt;
    logic [63:0] exp_pm;
    bit          exp_valid, exp_err;

    task automatic model_reset();
        m_sel = 0; m_init = 1; m_norm = 0; m_trk = 1; m_cnt = 0;
        exp_pm = '0; exp_valid = 0; exp_err = 0;
    endtask

    task automatic do_reset(input int cycles);
        Reset = 0; Active = 0; MMWriteEnable = 0; MMReadEnable = 0; MMSwap = 0;
        repeat (cycles) @(posedge Clock1);
        #1;
        model_reset();
        Reset = 1;
    endtask

    // One clock: drive inputs, let the edge happen, then advance the model from the pre-edge state.
    task automatic drive(input bit act, input bit we, input logic [5:0] wa, input logic [31:0] wd,
                         input bit re, input logic [4:0] ra, input bit sw);
        logic [31:0] w;
        logic [7:0]  v;
        int          s;
        Reset = 1; Active = act; MMWriteEnable = we; MMWriteAddress = wa; MMMetric = wd;
        MMReadEnable = re; MMReadAddress = ra; MMSwap = sw;
        @(posedge Clock1);
        exp_valid = act && re;
        exp_err = 0;
        if (act && re) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < 4; k++) begin
                    s = (2*int'(ra) + j)*4 + k;
                    if (m_init) begin
                        v = (s == 0) ? 8'h00 : 8'h3F;
                    end else begin
                        w = bank[m_sel ? 0 : 1][2*int'(ra) + j];
                        v = w[k*8 +: 8];
                        if (m_norm) v = v % 8'd128;
                    end
                    exp_pm[(j*4 + k)*8 +: 8] = v;
                end
            end
        end
        if (act && we) begin
            bank[m_sel][wa] = wd;
            if (m_cnt < 65) m_cnt++;
            for (int k = 0; k < 4; k++) if (wd[k*8 +: 8] < 8'd128) m_trk = 0;
        end
        if (act && sw) begin
            exp_err = (m_cnt != 64) && !m_init;
            m_norm = m_trk && !m_init;
            m_init = 0;
            m_sel = !m_sel;
            m_cnt = 0;
            m_trk = 1;
        end
        #1;
    endtask

    task automatic idle();
        drive(1, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (MMPathMetric !== 64'h0) begin failures++; $display("FAIL reset_pm got=%h exp=0", MMPathMetric); end
        checks++; if ({MMReadValid, MMBlockSelect, MMNormApplied, MMStepError} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {MMReadValid, MMBlockSelect, MMNormApplied, MMStepError});
        end
    endtask

    task automatic test_init_read();
        drive(1, 0, '0, '0, 1, 5'd0, 0);
        checks++; if (MMReadValid !== 1'b1) begin failures++; $display("FAIL init_valid got=%b exp=1", MMReadValid); end
        checks++; if (MMPathMetric !== 64'h3F3F3F3F_3F3F3F00) begin
            failures++; $display("FAIL init_r0 got=%h exp=3f3f3f3f3f3f3f00", MMPathMetric);
        end
        drive(1, 0, '0, '0, 1, 5'd17, 0);
        checks++; if (MMPathMetric !== 64'h3F3F3F3F_3F3F3F3F) begin
            failures++; $display("FAIL init_r17 got=%h exp=3f3f3f3f3f3f3f3f", MMPathMetric);
        end
        idle();
        checks++; if (MMReadValid !== 1'b0 || MMPathMetric !== 64'h3F3F3F3F_3F3F3F3F) begin
            failures++; $display("FAIL idle_hold got=%b/%h exp=0/3f3f3f3f3f3f3f3f", MMReadValid, MMPathMetric);
        end
    endtask

    task automatic test_first_steps();
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if ({MMBlockSelect, MMStepError, MMNormApplied} !== 3'b100) begin
            failures++; $display("FAIL first_swap got=%b exp=100", {MMBlockSelect, MMStepError, MMNormApplied});
        end
        for (int i = 0; i < 64; i++)
            drive(1, 1, 6'(i), (i == 0) ? 32'h01020304 : (i == 1) ? 32'h05060708 : 32'h10101010, 0, '0, 0);
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if ({MMBlockSelect, MMStepError, MMNormApplied} !== 3'b000) begin
            failures++; $display("FAIL second_swap got=%b exp=000", {MMBlockSelect, MMStepError, MMNormApplied});
        end
        drive(1, 0, '0, '0, 1, 5'd0, 0);
        checks++; if (MMPathMetric !== 64'h05060708_01020304) begin
            failures++; $display("FAIL bank_b_r0 got=%h exp=0506070801020304", MMPathMetric);
        end
        drive(1, 0, '0, '0, 1, 5'd9, 0);
        checks++; if (MMPathMetric !== 64'h10101010_10101010) begin
            failures++; $display("FAIL bank_b_r9 got=%h exp=1010101010101010", MMPathMetric);
        end
    endtask

    task automatic test_norm();
        for (int i = 0; i < 64; i++) drive(1, 1, 6'(i), 32'h80818283, 0, '0, 0);
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if (MMNormApplied !== 1'b1 || MMStepError !== 1'b0) begin
            failures++; $display("FAIL norm_set got=%b/%b exp=1/0", MMNormApplied, MMStepError);
        end
        drive(1, 0, '0, '0, 1, 5'd5, 0);
        checks++; if (MMPathMetric !== 64'h00010203_00010203) begin
            failures++; $display("FAIL norm_r5 got=%h exp=0001020300010203", MMPathMetric);
        end
        for (int i = 0; i < 64; i++)
            drive(1, 1, 6'(i), (i == 20) ? 32'h7F818283 : ($urandom | 32'h80808080), 1, 5'($urandom_range(0, 31)), 0);
        checks++; if (MMPathMetric !== exp_pm) begin failures++; $display("FAIL norm_rand_read got=%h exp=%h", MMPathMetric, exp_pm); end
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if (MMNormApplied !== 1'b0) begin failures++; $display("FAIL norm_clear got=%b exp=0", MMNormApplied); end
    endtask

    task automatic test_step_error();
        bit sel_before;
        for (int n = 63; n <= 65; n += 2) begin
            sel_before = MMBlockSelect;
            for (int i = 0; i < n; i++) drive(1, 1, 6'(i % 64), $urandom, 0, '0, 0);
            drive(1, 0, '0, '0, 0, '0, 1);
            checks++; if (MMStepError !== 1'b1) begin failures++; $display("FAIL step_err_%0d got=%b exp=1", n, MMStepError); end
            checks++; if (MMBlockSelect !== !sel_before) begin
                failures++; $display("FAIL step_err_toggle got=%b exp=%b", MMBlockSelect, !sel_before);
            end
            idle();
            checks++; if (MMStepError !== 1'b0) begin failures++; $display("FAIL step_err_pulse got=%b exp=0", MMStepError); end
        end
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < 63; i++) drive(1, 1, 6'(i), 32'h01010101 * (i % 16), 0, '0, 0);
        drive(1, 1, 6'd63, 32'h3F3E3D3C, 1, 5'd3, 1);
        checks++; if (MMStepError !== 1'b0) begin failures++; $display("FAIL same_cycle_err got=%b exp=0", MMStepError); end
        checks++; if (MMReadValid !== 1'b1 || MMPathMetric !== exp_pm) begin
            failures++; $display("FAIL same_cycle_read got=%b/%h exp=1/%h", MMReadValid, MMPathMetric, exp_pm);
        end
        drive(1, 0, '0, '0, 1, 5'd31, 0);
        checks++; if (MMPathMetric[63:32] !== 32'h3F3E3D3C) begin
            failures++; $display("FAIL same_cycle_land got=%h exp=3f3e3d3c", MMPathMetric[63:32]);
        end
    endtask

    task automatic test_active_gate();
        bit          sel_before;
        logic [63:0] pm_before;
        sel_before = MMBlockSelect;
        pm_before = MMPathMetric;
        for (int i = 0; i < 3; i++) drive(0, 1, 6'(i), 32'hDEADBEEF, 1, 5'(i), 1);
        checks++; if (MMReadValid !== 1'b0 || MMStepError !== 1'b0) begin
            failures++; $display("FAIL gate_flags got=%b/%b exp=0/0", MMReadValid, MMStepError);
        end
        checks++; if (MMBlockSelect !== sel_before || MMPathMetric !== pm_before) begin
            failures++; $display("FAIL gate_hold got=%b/%h exp=%b/%h", MMBlockSelect, MMPathMetric, sel_before, pm_before);
        end
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 6'(i), $urandom & 32'h7F7F7F7F, 0, '0, 0);
            if (i == 5) drive(0, 1, 6'd5, 32'h55555555, 0, '0, 0);
        end
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if (MMStepError !== 1'b0) begin failures++; $display("FAIL gate_count got=%b exp=0", MMStepError); end
        drive(1, 0, '0, '0, 1, 5'd2, 0);
        checks++; if (MMPathMetric !== exp_pm) begin failures++; $display("FAIL gate_nowrite got=%h exp=%h", MMPathMetric, exp_pm); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) drive(1, 1, 6'(i), $urandom, 0, '0, 0);
        do_reset(1);
        checks++; if ({MMReadValid, MMBlockSelect, MMNormApplied, MMStepError} !== 4'b0000 || MMPathMetric !== 64'h0) begin
            failures++; $display("FAIL mid_reset got=%b/%h exp=0000/0", {MMReadValid, MMBlockSelect, MMNormApplied, MMStepError}, MMPathMetric);
        end
        drive(1, 0, '0, '0, 1, 5'd0, 0);
        checks++; if (MMPathMetric !== 64'h3F3F3F3F_3F3F3F00) begin
            failures++; $display("FAIL mid_reset_init got=%h exp=3f3f3f3f3f3f3f00", MMPathMetric);
        end
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if (MMStepError !== 1'b0 || MMBlockSelect !== 1'b1) begin
            failures++; $display("FAIL mid_reset_swap got=%b/%b exp=0/1", MMStepError, MMBlockSelect);
        end
        for (int i = 0; i < 64; i++) drive(1, 1, 6'(i), $urandom, 0, '0, 0);
        drive(1, 0, '0, '0, 0, '0, 1);
        checks++; if (MMStepError !== 1'b0) begin failures++; $display("FAIL mid_reset_discard got=%b exp=0", MMStepError); end
        // Fill the other bank too so later random reads never see unwritten words.
        for (int i = 0; i < 64; i++) drive(1, 1, 6'(i), $urandom, 0, '0, 0);
        drive(1, 0, '0, '0, 0, '0, 1);
    endtask

    task automatic test_random();
        int          nwr;
        bit          msb_step, act;
        logic [31:0] wd;
        for (int step = 0; step < 8; step++) begin
            nwr = 63 + $urandom_range(0, 2);
            msb_step = $urandom_range(0, 1);
            for (int i = 0; i <= nwr; i++) begin
                act = ($urandom_range(0, 9) != 0);
                wd = msb_step ? ($urandom | 32'h80808080) : $urandom;
                if (i == nwr)
                    drive(1, $urandom_range(0, 2) == 0, 6'($urandom_range(0, 63)), wd, $urandom_range(0, 1), 5'($urandom_range(0, 31)), 1);
                else
                    drive(act, 1, (i < 64) ? 6'(i) : 6'($urandom_range(0, 63)), wd, $urandom_range(0, 1), 5'($urandom_range(0, 31)), 0);
                checks++; if (MMReadValid !== exp_valid) begin failures++; $display("FAIL rnd_valid got=%b exp=%b", MMReadValid, exp_valid); end
                checks++; if (MMPathMetric !== exp_pm) begin failures++; $display("FAIL rnd_pm got=%h exp=%h", MMPathMetric, exp_pm); end
                checks++; if ({MMBlockSelect, MMNormApplied, MMStepError} !== {m_sel, m_norm, exp_err}) begin
                    failures++; $display("FAIL rnd_ctrl got=%b exp=%b", {MMBlockSelect, MMNormApplied, MMStepError}, {m_sel, m_norm, exp_err});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_first_steps();
        test_norm();
        test_step_error();
        test_same_cycle();
        test_active_gate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
